// File: rtl/bank_arbiter_rr_pkg.sv
// -----------------------------------------------------------------------------
// bank_pkg
// Shared definitions for the bank arbiter slice: default bus widths, the
// address-window test and small one-hot / popcount helpers used by the
// arbiter and its round-robin core.
// -----------------------------------------------------------------------------
package bank_pkg;

   localparam int DEF_ADDR_WIDTH = 13;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int MAX_REQ        = 8;

   // Both bounds inclusive; two independent unsigned compares so a bank at
   // address 0 or at the top of the map needs no special casing.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (lo <= addr) && (addr <= hi);
   endfunction

   function automatic int unsigned popcount(input logic [MAX_REQ-1:0] v);
      int unsigned n;
      n = 0;
      for (int k = 0; k < MAX_REQ; k++) begin
         n = n + int'(v[k]);
      end
      return n;
   endfunction

   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (oh[k]) idx = 3'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bank_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// bank_arbiter_rr_if
// Requester-side bus of one BRAM bank: per-requester valid/ready handshake,
// write flag, packed addresses and write data, plus the one-hot read
// response and broadcast read data.
//   master : walk-engine side (drives requests, receives ready/response)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface bank_arbiter_rr_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/bank_arbiter_rr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant over an eligible vector. The grant is combinational from
// the current eligible set and pointer; the pointer advances past the winner
// only when the grant is actually accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_elig     : eligible requesters
//   i_accept   : grant taken this cycle
//   o_grant    : one-hot grant (all zero when nothing eligible)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_elig,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_grant
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   w_win;
   logic               w_found;
   logic [NUM_REQ-1:0] w_grant;

   // Scan ptr, ptr+1, ... with wrap; first eligible requester wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_grant = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_win   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
      if (w_found) w_grant[w_win] = 1'b1;
   end

   assign o_grant = w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
   end

endmodule

// File: rtl/bank_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bank_arbiter_rr
// Shares one single-port BRAM bank (global window LOWER_ADDR..UPPER_ADDR)
// among NUM_REQ walk engines. Filters requests to in-window addresses, grants
// one requester round-robin with a zero-cycle ready, registers the BRAM
// command and returns read data to the issuing requester RD_LATENCY+1 cycles
// after the accept. Also counts cycles with more than one eligible requester.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : requester handshake, addresses, write data, responses
//   mem_en/we/addr/wdata : registered BRAM command (addr is bank-local)
//   mem_rdata    : BRAM read data
//   conflict     : pulse, >1 eligible requester in the previous cycle
//   conflict_cnt : saturating count of conflict cycles
// -----------------------------------------------------------------------------
module bank_arbiter_rr
   import bank_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ    = 4,
   parameter int LOWER_ADDR = 0,
   parameter int UPPER_ADDR = 4,
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bank_arbiter_rr_if.slave      bus,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  conflict,
   output logic [CNT_WIDTH-1:0]  conflict_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ*ADDR_WIDTH-1:0] w_req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] w_req_wdata;
   logic [NUM_REQ-1:0]            w_in_win;
   logic [NUM_REQ-1:0]            w_elig;
   logic [NUM_REQ-1:0]            w_grant;
   logic                          w_accept;
   logic [IDX_W-1:0]              w_win;
   logic [ADDR_WIDTH-1:0]         w_sel_addr;

   logic                          r_mem_en;
   logic                          r_mem_we;
   logic [ADDR_WIDTH-1:0]         r_mem_addr;
   logic [DATA_WIDTH-1:0]         r_mem_wdata;
   logic [IDX_W-1:0]              r_iss_id;
   logic [RD_LATENCY-1:0]         r_pipe_vld;
   logic [RD_LATENCY-1:0][IDX_W-1:0] r_pipe_id;
   logic [NUM_REQ-1:0]            r_rsp_valid;
   logic [DATA_WIDTH-1:0]         r_rsp_rdata;
   logic                          r_conflict;
   logic [CNT_WIDTH-1:0]          r_conflict_cnt;

   assign w_req_addr  = bus.req_addr;
   assign w_req_wdata = bus.req_wdata;

   always_comb begin
      w_in_win = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_in_win[i] = in_window(32'(w_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                                 32'(LOWER_ADDR), 32'(UPPER_ADDR));
      end
   end

   // Gating with rst_n keeps req_ready low while the bank is held in reset.
   assign w_elig = bus.req_valid & w_in_win & {NUM_REQ{rst_n}};

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_elig   (w_elig),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   assign bus.req_ready = w_grant;
   assign w_accept      = |(bus.req_valid & w_grant);
   assign w_win         = IDX_W'(onehot_to_idx(MAX_REQ'(w_grant)));
   assign w_sel_addr    = w_req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];

   // ---- issue stage: BRAM command register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_iss_id    <= '0;
      end else if (w_accept) begin
         r_mem_en    <= 1'b1;
         r_mem_we    <= bus.req_we[w_win];
         r_mem_addr  <= w_sel_addr - ADDR_WIDTH'(LOWER_ADDR);
         r_mem_wdata <= w_req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
         r_iss_id    <= w_win;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
      end
   end

   // ---- BRAM latency stage: {valid, id} tracks reads in flight ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_vld <= '0;
         r_pipe_id  <= '0;
      end else begin
         r_pipe_vld[0] <= r_mem_en & ~r_mem_we;
         r_pipe_id[0]  <= r_iss_id;
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            r_pipe_id[k]  <= r_pipe_id[k-1];
         end
      end
   end

   // ---- response stage: capture BRAM data, pulse owner's valid ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else if (r_pipe_vld[RD_LATENCY-1]) begin
         r_rsp_valid <= NUM_REQ'(1) << r_pipe_id[RD_LATENCY-1];
         r_rsp_rdata <= mem_rdata;
      end else begin
         r_rsp_valid <= '0;
      end
   end

   // ---- contention monitor ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict     <= 1'b0;
         r_conflict_cnt <= '0;
      end else begin
         r_conflict <= (popcount(MAX_REQ'(w_elig)) > 1);
         if (r_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign mem_en        = r_mem_en;
   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign conflict      = r_conflict;
   assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: doc/bank_arbiter_rr.md
Name: bank_arbiter_rr

Overview:
- Shares one single-port BRAM bank (address window LOWER_ADDR..UPPER_ADDR) between NUM_REQ diffusion/random-walk engines.
- Per cycle: filters requests to in-window addresses, grants one requester round-robin, registers the BRAM command and routes the read data back to the granted requester after the BRAM latency.
- One instance per bank; sits between the walk engines and the bank BRAM.
- Also counts contention events for performance debug.

Parameters:
- ADDR_WIDTH, 13, global word address width.
- DATA_WIDTH, 32, data word width.
- NUM_REQ, 4, number of requesters (2..8).
- LOWER_ADDR, 0, first global address owned by this bank (inclusive).
- UPPER_ADDR, 4, last global address owned by this bank (inclusive).
- RD_LATENCY, 1, BRAM read latency in cycles, measured from mem_en sampled to mem_rdata valid (1..3).
- CNT_WIDTH, 16, contention counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant, combinational from the same cycle's inputs.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed global addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse.
- rsp_rdata  out  DATA_WIDTH  read data, broadcast to all requesters; qualified by rsp_valid.
- mem_en  out  1  BRAM enable (registered).
- mem_we  out  1  BRAM write enable (registered).
- mem_addr  out  ADDR_WIDTH  local address = global address − LOWER_ADDR (registered).
- mem_wdata  out  DATA_WIDTH  BRAM write data (registered).
- mem_rdata  in  DATA_WIDTH  BRAM read data.
- conflict  out  1  registered pulse: more than one in-window requester was valid in the previous cycle.
- conflict_cnt  out  CNT_WIDTH  saturating count of conflict cycles.

Behaviour:
- In-window check: in_win[i] = (LOWER_ADDR <= addr_i) && (addr_i <= UPPER_ADDR), two separate unsigned compares.
- Eligible set: elig = req_valid & in_win. Out-of-window requests are never granted here and req_ready stays 0 for them.
- Arbitration:
  - Round-robin pointer ptr (0..NUM_REQ-1). Winner = first set bit of elig scanning ptr, ptr+1, … with wrap.
  - req_ready = onehot(winner) when elig != 0, else 0. Zero-cycle grant; a transfer is accepted when valid & ready are both high at a posedge.
  - On an accepted transfer, ptr <= winner+1 modulo NUM_REQ. With no accept, ptr holds.
- Fairness: a continuously eligible requester is granted within NUM_REQ cycles.
- Issue stage, at the accept edge: mem_en=1, mem_we=req_we[w], mem_addr=addr_w−LOWER_ADDR (truncated to ADDR_WIDTH), mem_wdata=wdata_w. With no accept, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their values.
- Response pipeline:
  - A shift register of depth RD_LATENCY carries {valid, id}; a read accept enters valid=1, id=w.
  - Its output feeds a 1-cycle register stage: rsp_valid[id] and rsp_rdata <= mem_rdata.
  - Read accepted at edge T → mem_en high in cycle T..T+1 → rsp_valid high exactly one cycle, RD_LATENCY+1 cycles after T.
  - Writes produce no response.
  - Throughput: one access per cycle, fully pipelined; back-to-back reads from the same requester are allowed.
- Conflict: conflict <= (popcount(elig) > 1) every cycle. conflict_cnt increments when conflict is set and saturates at all-ones.
- Reset values: req_ready 0 (elig is gated by reset), rsp_valid 0, rsp_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, conflict 0, conflict_cnt 0, ptr 0, response pipeline cleared.
- Reset mid-operation: in-flight read responses are dropped and never delivered.
- Boundary cases:
  - Address equal to LOWER_ADDR or UPPER_ADDR is in window.
  - ptr wraps from NUM_REQ-1 to 0.
  - Only one requester eligible → granted regardless of ptr.
  - Requester deasserts valid while not granted → no state change.

Decomposition:
- Package bank_pkg holds: default ADDR_WIDTH/DATA_WIDTH, in-window function, one-hot/popcount helper functions.
- Sub-module rr_arbiter (NUM_REQ): inputs elig and accept, outputs one-hot grant, owns ptr.
- Top level holds the window check, issue registers, response pipeline and counters.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then release with no valids → all outputs 0, conflict_cnt=0.
- Single read: req0 reads addr 3, mem returns 0xDEADBEEF (RD_LATENCY=1) → mem_en, mem_addr=3 one cycle; rsp_valid=0001, rsp_rdata=0xDEADBEEF two cycles after accept.
- All 4 valid reading in-window continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; conflict high every cycle after the first; conflict_cnt=8.
- Window filter: LOWER_ADDR=5, UPPER_ADDR=9; req1 addr 4, req2 addr 9 → req2 granted, mem_addr=4; req1 never ready.
- Mixed write/read: req3 writes 0x55 to addr 2, then reads addr 2 → mem_we=1 then 0; rsp_valid=1000 only for the read, data 0x55.
- Reset mid-read: assert rst_n low one cycle after a read accept → no rsp_valid pulse afterwards; ptr=0.
